// File: rtl/mux81_rr_arbiter.sv
// rtl/mux81_rr_arbiter.sv - round-robin owner of an 8:1 data mux with valid/ready output
// Grants one requester at a time, streams its data, releases on request drop or HOLD_MAX beats.
module mux81_rr_arbiter #(
  parameter int DW       = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      req,
  input  logic [8*DW-1:0] din,
  input  logic            dout_ready,
  output logic [7:0]      grant,
  output logic [2:0]      sel,
  output logic [DW-1:0]   dout,
  output logic            dout_valid,
  output logic            busy
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(HOLD_MAX - 1);

  state_t     r_state;
  state_t     w_state_nx;
  logic [7:0] r_grant;
  logic [7:0] w_grant_nx;
  logic [2:0] r_sel;
  logic [2:0] w_sel_nx;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nx;
  logic [7:0] r_beat_cnt;
  logic [7:0] w_beat_cnt_nx;
  logic [2:0] w_winner;
  logic [2:0] w_idx;
  logic       w_found;
  logic       w_beat;

  // Search starts at ptr so the most recently released channel is checked last.
  always_comb begin
    w_winner = r_ptr;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < 8; i++) begin
      w_idx = r_ptr + 3'(i);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign busy       = (r_state == S_GRANT);
  assign dout_valid = busy & req[r_sel];
  assign dout       = busy ? din[r_sel*DW +: DW] : '0;
  assign w_beat     = dout_valid & dout_ready;
  assign grant      = r_grant;
  assign sel        = r_sel;

  always_comb begin
    w_state_nx    = r_state;
    w_grant_nx    = r_grant;
    w_sel_nx      = r_sel;
    w_ptr_nx      = r_ptr;
    w_beat_cnt_nx = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx    = S_GRANT;
          w_grant_nx    = 8'd1 << w_winner;
          w_sel_nx      = w_winner;
          w_beat_cnt_nx = '0;
        end
      end
      S_GRANT: begin
        if ((w_beat && (r_beat_cnt == LAST_BEAT)) || !req[r_sel]) begin
          w_state_nx = S_IDLE;
          w_grant_nx = '0;
          w_ptr_nx   = r_sel + 3'd1;
        end else if (w_beat) begin
          w_beat_cnt_nx = r_beat_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_grant    <= w_grant_nx;
      r_sel      <= w_sel_nx;
      r_ptr      <= w_ptr_nx;
      r_beat_cnt <= w_beat_cnt_nx;
    end
  end

endmodule

// File: tb/tb_mux81_rr_arbiter.sv
// tb/tb_mux81_rr_arbiter.sv - directed self-checking bench for mux81_rr_arbiter
module tb_mux81_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [63:0] din;
  logic        dout_ready;
  logic [7:0]  grant;
  logic [2:0]  sel;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        busy;

  int n_cmp;
  int n_bad;

  mux81_rr_arbiter #(.DW(8), .HOLD_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din        (din),
    .dout_ready (dout_ready),
    .grant      (grant),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req        = 8'hFF;
    dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== 8'h00) begin n_bad++; $display("FAIL reset_grant: got %h want 00", grant); end
    n_cmp++; if (sel !== 3'd0) begin n_bad++; $display("FAIL reset_sel: got %0d want 0", sel); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", dout); end
  endtask

  task automatic test_single();
    do_reset();
    req        = 8'h08;
    dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (grant !== 8'h08 || sel !== 3'd3) begin n_bad++; $display("FAIL single_grant beat%0d: got %h/%0d want 08/3", k, grant, sel); end
      n_cmp++; if (dout_valid !== 1'b1 || dout !== 8'hA3) begin n_bad++; $display("FAIL single_data beat%0d: got %b/%h want 1/a3", k, dout_valid, dout); end
    end
    @(negedge clk);
    n_cmp++; if (grant !== 8'h00 || busy !== 1'b0 || dout_valid !== 1'b0) begin n_bad++; $display("FAIL single_bubble: got %h/%b/%b want 00/0/0", grant, busy, dout_valid); end
    @(negedge clk);
    n_cmp++; if (grant !== 8'h08 || sel !== 3'd3) begin n_bad++; $display("FAIL single_regrant: got %h/%0d want 08/3", grant, sel); end
    req = 8'h00;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_drop: got busy %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    req        = 8'hFF;
    dout_ready = 1'b1;
    for (int g = 0; g < 9; g++) begin
      exp_g = 8'd1 << (g % 8);
      exp_d = 8'hA0 + 8'(g % 8);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        n_cmp++; if (grant !== exp_g || sel !== 3'(g % 8) || dout !== exp_d) begin n_bad++; $display("FAIL rr_grant g%0d beat%0d: got %h/%0d/%h want %h/%0d/%h", g, k, grant, sel, dout, exp_g, g % 8, exp_d); end
      end
      @(negedge clk);
      n_cmp++; if (grant !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL rr_bubble g%0d: got %h/%b want 00/0", g, grant, busy); end
    end
    req = 8'h00;
  endtask

  task automatic test_early_drop();
    do_reset();
    req        = 8'h60;
    dout_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (grant !== 8'h20 || dout !== 8'hA5) begin n_bad++; $display("FAIL drop_grant beat%0d: got %h/%h want 20/a5", k, grant, dout); end
    end
    @(negedge clk);
    req = 8'h40;
    #1;
    n_cmp++; if (dout_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL drop_valid: got %b/%b want 0/1", dout_valid, busy); end
    @(negedge clk);
    n_cmp++; if (grant !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL drop_release: got %h/%b want 00/0", grant, busy); end
    @(negedge clk);
    n_cmp++; if (grant !== 8'h40 || sel !== 3'd6) begin n_bad++; $display("FAIL drop_next: got %h/%0d want 40/6", grant, sel); end
    req = 8'h00;
  endtask

  task automatic test_backpressure();
    int beats;
    int guard;
    do_reset();
    req        = 8'h04;
    dout_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++; if (grant !== 8'h04 || sel !== 3'd2 || dout !== 8'hA2 || dout_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold cyc%0d: got %h/%0d/%h/%b want 04/2/a2/1", k, grant, sel, dout, dout_valid); end
    end
    dout_ready = 1'b1;
    beats = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 20) begin
      if (dout_valid === 1'b1 && dout_ready === 1'b1) beats++;
      @(negedge clk);
      guard++;
    end
    n_cmp++; if (beats != 4) begin n_bad++; $display("FAIL bp_beats: got %0d want 4", beats); end
    req = 8'h00;
  endtask

  task automatic test_async_reset();
    do_reset();
    req        = 8'h10;
    dout_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (grant !== 8'h10 || busy !== 1'b1) begin n_bad++; $display("FAIL areset_pre: got %h/%b want 10/1", grant, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (grant !== 8'h00 || busy !== 1'b0 || dout_valid !== 1'b0 || sel !== 3'd0 || dout !== 8'h00) begin n_bad++; $display("FAIL areset_now: got %h/%b/%b/%0d/%h want 00/0/0/0/00", grant, busy, dout_valid, sel, dout); end
    req = 8'h30;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (grant !== 8'h10 || sel !== 3'd4) begin n_bad++; $display("FAIL areset_ptr: got %h/%0d want 10/4", grant, sel); end
    req = 8'h00;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    req        = 8'h00;
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'hA0 + 8'(i);
    test_reset();
    test_single();
    test_round_robin();
    test_early_drop();
    test_backpressure();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
